store_rmw_unit: RTL

//  Write-side counterpart to the load byte/halfword extractor. Accepts byte, halfword and word

---
 rtl/store_rmw_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/store_rmw_unit.sv
// rtl/store_rmw_unit.sv - Byte/halfword/word store unit doing read-modify-write on a word-only memory
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   st_valid/st_ready           store request handshake (ready only while idle)
//   st_addr, st_size, st_data   byte address, size (00 byte, 01 half, 1x word), right-justified data
//   st_done                     one-cycle completion pulse
//   mem_addr, mem_re, mem_rdata memory word address, read strobe, read data (MEM_RD_LAT cycles later)
//   mem_we, mem_wdata           memory write strobe and merged write word
//   st_err                      misalignment trap pulse, only with MISALIGN_TRAP_EN defined
//
// Build option: MISALIGN_TRAP_EN - misaligned half/word stores complete with st_err
// instead of touching memory.
module store_rmw_unit #(
    parameter int ADDR_W     = 32,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [1:0]        st_size,
    input  logic [31:0]       st_data,
    output logic              st_done,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              st_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        off_q, off_d;
    logic              byte_q, byte_d;
    logic [15:0]       data_q, data_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              st_done_q, st_done_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
`ifdef MISALIGN_TRAP_EN
    logic              st_err_q, st_err_d;
`endif

    logic        accept;
    logic        is_word;
    logic        trap;
    logic [31:0] merged;

    assign accept  = st_valid && (state_q == S_IDLE);
    assign is_word = st_size[1];

`ifdef MISALIGN_TRAP_EN
    assign trap = ((st_size == 2'b01) && st_addr[0]) || (is_word && (st_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Merge the latched lane into the word arriving from memory this cycle.
    always_comb begin
        merged = mem_rdata;
        if (byte_q) begin
            case (off_q)
                2'd0:    merged[7:0]   = data_q[7:0];
                2'd1:    merged[15:8]  = data_q[7:0];
                2'd2:    merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[31:16] = data_q;
        end else begin
            merged[15:0] = data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            off_q       <= 2'd0;
            byte_q      <= 1'b0;
            data_q      <= 16'd0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            st_done_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            st_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            byte_q      <= byte_d;
            data_q      <= data_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            st_done_q   <= st_done_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef MISALIGN_TRAP_EN
            st_err_q    <= st_err_d;
`endif
        end
    end

    // Trapped stores reuse WRITE as their single busy cycle, with no strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = (trap || is_word) ? S_WRITE : S_READ;
            end
            S_READ: begin
                state_d = S_WAIT;
                cnt_d   = 2'(MEM_RD_LAT - 1);
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) state_d = S_WRITE;
                else               cnt_d   = cnt_q - 2'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so strobes are computed one cycle ahead of the state they belong to.
    always_comb begin
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        st_done_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        off_d       = off_q;
        byte_d      = byte_q;
        data_d      = data_q;
`ifdef MISALIGN_TRAP_EN
        st_err_d    = 1'b0;
`endif
        if (accept) begin
            off_d  = st_addr[1:0];
            byte_d = (st_size == 2'b00);
            data_d = st_data[15:0];
            if (trap) begin
                st_done_d = 1'b1;
`ifdef MISALIGN_TRAP_EN
                st_err_d  = 1'b1;
`endif
            end else begin
                mem_addr_d = st_addr[ADDR_W-1:2];
                if (is_word) begin
                    mem_we_d    = 1'b1;
                    st_done_d   = 1'b1;
                    mem_wdata_d = st_data;
                end else begin
                    mem_re_d = 1'b1;
                end
            end
        end
        // Last WAIT cycle: read data is valid now, merge it straight into the write register.
        if ((state_q == S_WAIT) && (cnt_q == 2'd0)) begin
            mem_we_d    = 1'b1;
            st_done_d   = 1'b1;
            mem_wdata_d = merged;
        end
    end

    assign st_ready  = (state_q == S_IDLE);
    assign st_done   = st_done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
`ifdef MISALIGN_TRAP_EN
    assign st_err    = st_err_q;
`endif

endmodule
